// File: rtl/tl_mem_mp.sv
// rtl/tl_mem_mp.sv - multi-port TileLink-UL memory slave over one shared word RAM
// Round-robin arbitrated, one transaction in flight, Get/Put bursts with denied responses.
module tl_mem_mp #(
  parameter int              NP    = 2,
  parameter int              DW    = 128,
  parameter int              DEPTH = 16384,
  parameter int              AW    = 32,
  parameter int              SW    = 3,
  parameter logic [AW-1:0]   BASE  = 'h80000000,
  parameter int              LAT   = 1
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [NP-1:0]          a_valid,
  output logic [NP-1:0]          a_ready,
  input  logic [3*NP-1:0]        a_opcode,
  input  logic [3*NP-1:0]        a_param,
  input  logic [8*NP-1:0]        a_size,
  input  logic [SW*NP-1:0]       a_source,
  input  logic [AW*NP-1:0]       a_address,
  input  logic [(DW/8)*NP-1:0]   a_mask,
  input  logic [DW*NP-1:0]       a_data,
  input  logic [NP-1:0]          a_corrupt,
  output logic [NP-1:0]          d_valid,
  input  logic [NP-1:0]          d_ready,
  output logic [3*NP-1:0]        d_opcode,
  output logic [2*NP-1:0]        d_param,
  output logic [8*NP-1:0]        d_size,
  output logic [SW*NP-1:0]       d_source,
  output logic [3*NP-1:0]        d_sink,
  output logic [NP-1:0]          d_denied,
  output logic [DW*NP-1:0]       d_data,
  output logic [NP-1:0]          d_corrupt
);

  localparam int BB = DW / 8;
  localparam int LB = $clog2(BB);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PUT  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  logic [1:0]    state;
  logic [PW-1:0] rr;
  logic [PW-1:0] port;
  logic [2:0]    op_r;
  logic [7:0]    size_r;
  logic [SW-1:0] src_r;
  logic [AW-1:0] idx_r;
  logic [31:0]   beats_r;
  logic [31:0]   beat;
  logic          den_r;
  logic [15:0]   lat_cnt;
  logic [DW-1:0] rdata;

  logic [DW-1:0] mem [DEPTH];

  logic unused_in;
  assign unused_in = ^{a_param, a_corrupt};

  logic          win_found;
  logic [PW-1:0] win;
  always_comb begin
    int p;
    p = 0;
    win_found = 1'b0;
    win = '0;
    // Scan downward so the candidate closest to the pointer is the last one kept.
    for (int k = NP - 1; k >= 0; k--) begin
      p = (int'(rr) + k) % NP;
      if (a_valid[p]) begin
        win_found = 1'b1;
        win = PW'(p);
      end
    end
  end

  logic [2:0]    w_op;
  logic [7:0]    w_size;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_off;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_beats;
  logic          w_big;
  logic          w_den;
  logic          w_is_put;
  always_comb begin
    w_op     = a_opcode[3*win +: 3];
    w_size   = a_size[8*win +: 8];
    w_addr   = a_address[AW*win +: AW];
    w_off    = w_addr - BASE;
    w_idx    = w_off >> LB;
    w_big    = (w_size > 8'(LB + 30));
    w_beats  = (w_size <= 8'(LB) || w_big) ? 32'd1 : (32'd1 << (w_size - 8'(LB)));
    w_is_put = (w_op == OP_PUT_FULL) || (w_op == OP_PUT_PART);
    w_den    = (w_addr < BASE) || w_big ||
               (64'(w_idx) + 64'(w_beats) > 64'(DEPTH)) ||
               !(w_is_put || (w_op == OP_GET));
  end

  always_comb begin
    a_ready = '0;
    if (RSTn) begin
      if (state == IDLE && win_found) a_ready[win] = 1'b1;
      else if (state == PUT)          a_ready[port] = 1'b1;
    end
  end

  logic fire_a;
  logic put_fire;
  assign fire_a   = (state == IDLE) && win_found && a_valid[win] && a_ready[win];
  assign put_fire = (state == PUT) && a_valid[port] && a_ready[port];

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic [BB-1:0] wr_mask;
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = w_idx[IW-1:0];
    wr_data = a_data[DW*win +: DW];
    wr_mask = a_mask[BB*win +: BB];
    if (state == IDLE) begin
      wr_en = fire_a && w_is_put && !w_den;
    end else if (state == PUT) begin
      wr_idx  = IW'(idx_r + beat);
      wr_data = a_data[DW*port +: DW];
      wr_mask = a_mask[BB*port +: BB];
      wr_en   = put_fire && !den_r;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int b = 0; b < BB; b++) begin
        if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state   <= IDLE;
      rr      <= '0;
      port    <= '0;
      op_r    <= '0;
      size_r  <= '0;
      src_r   <= '0;
      idx_r   <= '0;
      beats_r <= '0;
      beat    <= '0;
      den_r   <= 1'b0;
      lat_cnt <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire_a) begin
            port    <= win;
            op_r    <= w_op;
            size_r  <= w_size;
            src_r   <= a_source[SW*win +: SW];
            idx_r   <= w_idx;
            beats_r <= w_beats;
            den_r   <= w_den;
            rr      <= PW'((int'(win) + 1) % NP);
            lat_cnt <= '0;
            if (w_is_put && w_beats > 32'd1) begin
              state <= PUT;
              beat  <= 32'd1;
            end else begin
              state <= WAIT;
              beat  <= '0;
            end
          end
        end
        PUT: begin
          if (put_fire) begin
            if (beat == beats_r - 32'd1) begin
              state <= WAIT;
              beat  <= '0;
            end else begin
              beat <= beat + 32'd1;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == 16'(LAT - 1)) begin
            state <= RESP;
            rdata <= (op_r == OP_GET && !den_r) ? mem[IW'(idx_r)] : '0;
          end else begin
            lat_cnt <= lat_cnt + 16'd1;
          end
        end
        default: begin
          if (d_ready[port]) begin
            if (op_r != OP_GET || beat == beats_r - 32'd1) begin
              state <= IDLE;
              beat  <= '0;
            end else begin
              beat  <= beat + 32'd1;
              // Prefetch the next burst word so d_data stays registered.
              rdata <= den_r ? '0 : mem[IW'(idx_r + beat + 32'd1)];
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    d_valid   = '0;
    d_opcode  = '0;
    d_param   = '0;
    d_size    = '0;
    d_source  = '0;
    d_sink    = '0;
    d_denied  = '0;
    d_data    = '0;
    d_corrupt = '0;
    if (state == RESP) begin
      d_valid[port]             = 1'b1;
      d_opcode[3*port +: 3]     = (op_r == OP_GET) ? 3'd1 : 3'd0;
      d_size[8*port +: 8]       = size_r;
      d_source[SW*port +: SW]   = src_r;
      d_denied[port]            = den_r;
      d_data[DW*port +: DW]     = rdata;
      d_corrupt[port]           = den_r && (op_r == OP_GET);
    end
  end

endmodule

// File: tb/tb_tl_mem_mp.sv
// tb/tb_tl_mem_mp.sv - self-checking bench for tl_mem_mp
// Scoreboard of expected D beats built from observed A fires and a reference word array.
module tb_tl_mem_mp;

  localparam int          NP    = 2;
  localparam int          DW    = 128;
  localparam int          DEPTH = 256;
  localparam int          AW    = 32;
  localparam int          SW    = 3;
  localparam int          LAT   = 1;
  localparam logic [31:0] BASE  = 32'h80000000;

  logic              CLK;
  logic              RSTn;
  logic [NP-1:0]     a_valid;
  logic [NP-1:0]     a_ready;
  logic [3*NP-1:0]   a_opcode;
  logic [3*NP-1:0]   a_param;
  logic [8*NP-1:0]   a_size;
  logic [SW*NP-1:0]  a_source;
  logic [AW*NP-1:0]  a_address;
  logic [16*NP-1:0]  a_mask;
  logic [DW*NP-1:0]  a_data;
  logic [NP-1:0]     a_corrupt;
  logic [NP-1:0]     d_valid;
  logic [NP-1:0]     d_ready;
  logic [3*NP-1:0]   d_opcode;
  logic [2*NP-1:0]   d_param;
  logic [8*NP-1:0]   d_size;
  logic [SW*NP-1:0]  d_source;
  logic [3*NP-1:0]   d_sink;
  logic [NP-1:0]     d_denied;
  logic [DW*NP-1:0]  d_data;
  logic [NP-1:0]     d_corrupt;

  tl_mem_mp #(.NP(NP), .DW(DW), .DEPTH(DEPTH), .AW(AW), .SW(SW), .BASE(BASE), .LAT(LAT)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int           port;
    logic [2:0]   op;
    logic [7:0]   size;
    logic [2:0]   src;
    logic         den;
    logic         cor;
    logic         chk;
    logic [127:0] data;
    logic         last;
  } beat_t;

  logic [127:0] mref [DEPTH];
  beat_t        exp_q[$];
  int           fire_log[$];
  int checks = 0, errors = 0;
  int fire_cnt = 0, abeat_cnt = 0, pops = 0, done_cnt = 0, stalls = 0;
  int cyc = 0, fire_cyc = 0, first_dv_cyc = 0;
  logic await_first = 1'b0;
  logic [127:0] last_rdata = '0;
  logic last_den = 1'b0;
  logic [2:0] last_op = '0;
  logic rst_q = 1'b0;
  logic stall_mode = 1'b0;
  logic in_put = 1'b0;
  int pp, pidx, pbeats, pk;
  logic pden;
  logic [7:0] psize;
  logic [2:0] psrc;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int f_beats(logic [7:0] s);
    return (s <= 8'd4) ? 1 : ((1 << s) / 16);
  endfunction

  function automatic logic f_den(logic [31:0] addr, logic [2:0] op, logic [7:0] s);
    if (addr < BASE) return 1'b1;
    if (int'((addr - BASE) / 16) + f_beats(s) > DEPTH) return 1'b1;
    return !(op == 3'd0 || op == 3'd1 || op == 3'd4);
  endfunction

  task automatic mwrite(int idx, logic [15:0] m, logic [127:0] d);
    for (int b = 0; b < 16; b++)
      if (m[b]) mref[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  always @(posedge CLK) rst_q <= RSTn;

  always @(posedge CLK) begin
    #2;
    if (stall_mode) d_ready = ~d_ready;
  end

  always @(negedge CLK) begin
    int dp;
    beat_t e, b;
    logic [2:0] op;
    logic [7:0] sz;
    logic [31:0] addr;
    logic den;
    int nb, idx;
    cyc++;
    if (!rst_q) begin
      exp_q.delete();
      in_put = 1'b0;
      chk("rst_d_valid", 128'(d_valid), 128'd0);
      chk("rst_a_ready", 128'(a_ready), 128'd0);
      chk("rst_d_denied", 128'(d_denied), 128'd0);
    end else begin
      if (d_valid != '0) begin
        chk("d_valid_onehot", 128'($countones(d_valid)), 128'd1);
        dp = d_valid[1] ? 1 : 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_d_valid", 128'(d_valid), 128'd0);
        end else begin
          e = exp_q[0];
          if (await_first) begin first_dv_cyc = cyc; await_first = 1'b0; end
          chk("d_port", 128'(dp), 128'(e.port));
          chk("d_opcode", 128'(d_opcode[3*dp +: 3]), 128'(e.op));
          chk("d_size", 128'(d_size[8*dp +: 8]), 128'(e.size));
          chk("d_source", 128'(d_source[3*dp +: 3]), 128'(e.src));
          chk("d_denied", 128'(d_denied[dp]), 128'(e.den));
          chk("d_corrupt", 128'(d_corrupt[dp]), 128'(e.cor));
          chk("d_param_sink", 128'({d_param, d_sink}), 128'd0);
          if (e.chk) chk("d_data", d_data[128*dp +: 128], e.data);
          if (d_ready[dp] && RSTn) begin
            pops++;
            last_rdata = d_data[128*dp +: 128];
            last_den = d_denied[dp];
            last_op = d_opcode[3*dp +: 3];
            void'(exp_q.pop_front());
            if (e.last) done_cnt++;
          end else if (!d_ready[dp]) begin
            stalls++;
          end
        end
      end
      if (RSTn) begin
        for (int p = 0; p < NP; p++) begin
          if (a_valid[p] && a_ready[p]) begin
            abeat_cnt++;
            if (in_put) begin
              if (!pden) mwrite(pidx + pk, a_mask[16*p +: 16], a_data[128*p +: 128]);
              pk++;
              if (pk == pbeats) begin
                in_put = 1'b0;
                b.port = pp; b.op = 3'd0; b.size = psize; b.src = psrc; b.den = pden;
                b.cor = 1'b0; b.chk = 1'b0; b.data = '0; b.last = 1'b1;
                exp_q.push_back(b);
              end
            end else begin
              op = a_opcode[3*p +: 3];
              sz = a_size[8*p +: 8];
              addr = a_address[32*p +: 32];
              den = f_den(addr, op, sz);
              nb = f_beats(sz);
              idx = den ? 0 : int'((addr - BASE) / 16);
              fire_log.push_back(p);
              fire_cnt++;
              fire_cyc = cyc;
              await_first = 1'b1;
              b.port = p; b.size = sz; b.src = a_source[3*p +: 3]; b.den = den;
              if (op == 3'd4) begin
                for (int k = 0; k < nb; k++) begin
                  b.op = 3'd1; b.cor = den; b.chk = 1'b1;
                  b.data = den ? 128'd0 : mref[idx + k];
                  b.last = (k == nb - 1);
                  exp_q.push_back(b);
                end
              end else begin
                if ((op == 3'd0 || op == 3'd1) && !den)
                  mwrite(idx, a_mask[16*p +: 16], a_data[128*p +: 128]);
                if ((op == 3'd0 || op == 3'd1) && nb > 1) begin
                  in_put = 1'b1; pp = p; pidx = idx; pbeats = nb; pk = 1;
                  pden = den; psize = sz; psrc = a_source[3*p +: 3];
                end else begin
                  b.op = 3'd0; b.cor = 1'b0; b.chk = 1'b0; b.data = '0; b.last = 1'b1;
                  exp_q.push_back(b);
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic set_fields(int p, logic [2:0] op, logic [7:0] sz, logic [31:0] addr,
                            logic [2:0] src, logic [15:0] m, logic [127:0] d);
    a_opcode[3*p +: 3] = op;
    a_size[8*p +: 8] = sz;
    a_address[32*p +: 32] = addr;
    a_source[3*p +: 3] = src;
    a_mask[16*p +: 16] = m;
    a_data[128*p +: 128] = d;
  endtask

  task automatic issue(int p, logic [2:0] op, logic [7:0] sz, logic [31:0] addr,
                       logic [2:0] src, logic [15:0] m, logic [127:0] d, output int waited);
    int nb, t, f0;
    nb = (op == 3'd0 || op == 3'd1) ? f_beats(sz) : 1;
    set_fields(p, op, sz, addr, src, m, d);
    a_valid[p] = 1'b1;
    waited = 0;
    for (int k = 0; k < nb; k++) begin
      a_data[128*p +: 128] = d + 128'(k);
      f0 = abeat_cnt;
      t = 0;
      while (abeat_cnt == f0 && t < 50) begin
        @(posedge CLK); #1;
        t++;
      end
      if (k == 0) waited = t;
      if (abeat_cnt == f0) chk("a_accept_timeout", 128'(t), 128'd0);
    end
    a_valid[p] = 1'b0;
  endtask

  task automatic wait_done(int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 100) begin
      @(posedge CLK); #1;
      t++;
    end
    if (done_cnt < target) chk("d_done_timeout", 128'(done_cnt), 128'(target));
  endtask

  task automatic xact(int p, logic [2:0] op, logic [7:0] sz, logic [31:0] addr,
                      logic [2:0] src, logic [15:0] m, logic [127:0] d);
    int d0, w;
    d0 = done_cnt;
    issue(p, op, sz, addr, src, m, d, w);
    wait_done(d0 + 1);
  endtask

  task automatic apply_reset();
    RSTn = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    RSTn = 1'b1;
    @(posedge CLK); #1;
  endtask

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_CC = {16{8'hCC}};
  localparam logic [127:0] PAT_11 = {16{8'h11}};
  localparam logic [127:0] PAT_77 = {16{8'h77}};
  localparam logic [127:0] PAT_BR = 128'h0123456789ABCDEF_FEDCBA9876543210;

  initial begin
    int w, d0, f0, p0, t;
    RSTn = 1'b0;
    a_valid = '0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '0; a_data = '0; a_corrupt = '0;
    d_ready = 2'b11;
    repeat (3) begin @(posedge CLK); #1; end
    RSTn = 1'b1;
    @(posedge CLK); #1;
    chk("post_reset_d_valid", 128'(d_valid), 128'd0);

    xact(0, 3'd0, 8'd4, 32'h80000010, 3'd1, 16'hFFFF, PAT_A5);
    xact(0, 3'd0, 8'd4, 32'h80000020, 3'd2, 16'hFFFF, PAT_CC);
    xact(1, 3'd0, 8'd6, 32'h80000040, 3'd3, 16'hFFFF, PAT_BR);
    xact(1, 3'd0, 8'd4, 32'h80000FE0, 3'd4, 16'hFFFF, PAT_77);

    xact(0, 3'd4, 8'd4, 32'h80000010, 3'd5, 16'hFFFF, '0);
    chk("get_latency", 128'(first_dv_cyc - fire_cyc), 128'd2);
    chk("get_data_a5", last_rdata, PAT_A5);
    chk("get_opcode", 128'(last_op), 128'd1);
    chk("get_not_denied", 128'(last_den), 128'd0);

    xact(1, 3'd1, 8'd4, 32'h80000020, 3'd6, 16'h00FF, PAT_11);
    chk("partial_put_ack", 128'(last_op), 128'd0);
    xact(1, 3'd4, 8'd4, 32'h80000020, 3'd7, 16'hFFFF, '0);
    chk("partial_put_data", last_rdata, {{8{8'hCC}}, {8{8'h11}}});

    p0 = stalls;
    d_ready = 2'b01;
    stall_mode = 1'b1;
    xact(0, 3'd4, 8'd6, 32'h80000040, 3'd0, 16'hFFFF, '0);
    stall_mode = 1'b0;
    d_ready = 2'b11;
    chk("burst_stall_seen", 128'(stalls > p0), 128'd1);
    chk("burst_last_beat", last_rdata, PAT_BR + 128'd3);
    d0 = done_cnt;
    issue(0, 3'd4, 8'd4, 32'h80000010, 3'd1, 16'hFFFF, '0, w);
    chk("idle_after_burst", 128'(w), 128'd1);
    wait_done(d0 + 1);

    xact(1, 3'd4, 8'd4, 32'h7FFFFFF0, 3'd2, 16'hFFFF, '0);
    chk("deny_low_flag", 128'(last_den), 128'd1);
    chk("deny_low_data", last_rdata, 128'd0);
    xact(0, 3'd4, 8'd4, BASE + 32'(DEPTH * 16), 3'd3, 16'hFFFF, '0);
    chk("deny_high_flag", 128'(last_den), 128'd1);
    chk("deny_high_data", last_rdata, 128'd0);
    xact(0, 3'd1, 8'd6, 32'h80000FE0, 3'd4, 16'hFFFF, {16{8'hDE}});
    chk("deny_put_flag", 128'(last_den), 128'd1);
    chk("deny_put_ack", 128'(last_op), 128'd0);
    xact(1, 3'd4, 8'd4, 32'h80000FE0, 3'd5, 16'hFFFF, '0);
    chk("deny_put_nowrite", last_rdata, PAT_77);

    p0 = pops;
    issue(0, 3'd4, 8'd6, 32'h80000040, 3'd6, 16'hFFFF, '0, w);
    t = 0;
    while (pops < p0 + 1 && t < 50) begin @(posedge CLK); #1; t++; end
    chk("reset_test_beat1", 128'(pops >= p0 + 1), 128'd1);
    RSTn = 1'b0;
    set_fields(1, 3'd4, 8'd4, 32'h80000010, 3'd1, 16'hFFFF, '0);
    a_valid[1] = 1'b1;
    @(posedge CLK); #1;
    chk("midreset_d_valid", 128'(d_valid), 128'd0);
    chk("midreset_a_ready", 128'(a_ready), 128'd0);
    @(posedge CLK); #1;
    a_valid = '0;
    RSTn = 1'b1;
    @(posedge CLK); #1;
    xact(1, 3'd4, 8'd4, 32'h80000010, 3'd7, 16'hFFFF, '0);
    chk("after_reset_get", last_rdata, PAT_A5);

    apply_reset();
    set_fields(0, 3'd4, 8'd4, 32'h80000010, 3'd1, 16'hFFFF, '0);
    set_fields(1, 3'd4, 8'd4, 32'h80000020, 3'd2, 16'hFFFF, '0);
    d0 = done_cnt;
    f0 = fire_log.size();
    a_valid = 2'b11;
    wait_done(d0 + 4);
    a_valid = '0;
    repeat (3) begin @(posedge CLK); #1; end
    chk("rr_fire_count", 128'(fire_log.size() - f0), 128'd4);
    if (fire_log.size() >= f0 + 4) begin
      chk("rr_order0", 128'(fire_log[f0]), 128'd0);
      chk("rr_order1", 128'(fire_log[f0 + 1]), 128'd1);
      chk("rr_order2", 128'(fire_log[f0 + 2]), 128'd0);
      chk("rr_order3", 128'(fire_log[f0 + 3]), 128'd1);
    end
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired cycles=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/tl_mem_mp.md
Name: tl_mem_mp

Overview:
- Parametrised multi-port TileLink-UL memory slave. It serves NP independent A/D channel pairs from one shared word-organised RAM.
- Simulation/FPGA successor to the single-port bench memory: configurable width, depth, base address and response latency.
- Adds round-robin arbitration, multi-beat Get/Put bursts and denied responses for out-of-range or unsupported requests.
- Sits between core L1 channels (il1, dl1, ...) and backing storage in chip-level benches.

Parameters:
- NP, 2, number of A/D port pairs
- DW, 128, data bus width in bits (power of two, >=64)
- DEPTH, 16384, RAM depth in DW-bit words
- AW, 32, address width
- SW, 3, source id width
- BASE, 32'h80000000, byte address of word 0
- LAT, 1, cycles from A acceptance to first D beat (>=1)

Ports:
- CLK  in  1  clock
- RSTn  in  1  synchronous active-low reset
- a_valid  in  NP  per-port A valid
- a_ready  out  NP  per-port A ready
- a_opcode  in  3*NP  A opcode
- a_param  in  3*NP  A param (ignored)
- a_size  in  8*NP  log2 bytes
- a_source  in  SW*NP  A source id
- a_address  in  AW*NP  byte address
- a_mask  in  (DW/8)*NP  byte lane mask
- a_data  in  DW*NP  write data
- a_corrupt  in  NP  ignored
- d_valid  out  NP  per-port D valid
- d_ready  in  NP  per-port D ready
- d_opcode  out  3*NP  0 AccessAck, 1 AccessAckData
- d_param  out  2*NP  always 0
- d_size  out  8*NP  echoed a_size
- d_source  out  SW*NP  echoed a_source
- d_sink  out  3*NP  always 0
- d_denied  out  NP  request rejected
- d_data  out  DW*NP  read data
- d_corrupt  out  NP  equals d_denied on AccessAckData, else 0

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (RSTn sampled on CLK rising edge).
- Reset values: state IDLE; all a_ready=0, d_valid=0, d_denied=0; RR pointer=0; beat and latency counters 0. RAM contents are not cleared.
- Reset mid-transaction aborts it silently; no D response is issued.
- Transaction model: one transaction in flight globally.
- FSM states: IDLE, PUT, WAIT, RESP.
- Arbitration (IDLE):
  - Winner is the first asserting a_valid at or after the RR pointer, wrapping modulo NP.
  - a_ready[winner]=1 combinationally in IDLE only; all other a_ready=0.
  - On the fire, latch port, opcode, size, source and address. RR pointer <= winner+1 mod NP.
- Beat count: BEATS = (2^size <= DW/8) ? 1 : 2^size/(DW/8).
- Word index: idx = (address-BASE)>>log2(DW/8), plus beat number for beat k.
- Denied: the request is denied when (address-BASE) underflows, idx+BEATS > DEPTH, or opcode is not in {0,1,4}.
- Get (4), transitions: IDLE -> WAIT.
- Put (0/1), transitions:
  - Beat 0 is written on the fire using a_mask; for opcode 0 the mask is still honoured.
  - If BEATS>1, go to PUT. In PUT, a_ready is asserted only for the latched port; accept BEATS-1 further beats at idx+1..; then go to WAIT.
  - Denied puts still consume all beats but write nothing.
- WAIT: count LAT-1 cycles (LAT=1 means zero extra cycles), then go to RESP.
- RESP:
  - d_valid asserted on the latched port only, with d_source and d_size echoed.
  - Get: BEATS beats of AccessAckData, RAM[idx+k] on beat k.
  - Put: one AccessAck beat.
  - Beat advances on d_valid&d_ready. d_valid and d_data are held stable while stalled.
  - After the last beat fires, go to IDLE. The next A fire can happen the following cycle.
- Denied Get: d_data=0, d_denied=1, d_corrupt=1 on every beat.
- Read-after-write: a Get issued after a Put's AccessAck observes the new data.
- Simultaneous a_valid on all ports: exactly one fire per IDLE visit. Sustained requests are served in rotation, with no starvation.
- Requests with 2^size < DW/8 use a single beat with lanes selected by a_mask. Read data returns the full word.

Test Plan:
- NP=2, LAT=1, port0 Get size=4 addr 0x80000010 with RAM[1]=0xA5..A5 -> a_ready[0]=1 in the fire cycle; d_valid[0] 2 cycles after the fire; d_opcode=1, d_data=0xA5..A5, d_denied=0.
- Port1 PutPartialData size=4 addr 0x80000020, mask 0x00FF, data 0x11..11, then Get of the same address -> AccessAck (d_opcode=0); read returns the low 8 bytes 0x11, upper bytes unchanged.
- Both ports hold a Get valid continuously, with the RR pointer at 0 after reset -> service order 0,1,0,1; each port gets exactly one response per two transactions.
- Port0 Get size=6 (4 beats), d_ready toggling 1,0,1,0 -> 4 beats with data RAM[idx..idx+3] in order; data held during the stall cycles; FSM returns to IDLE after beat 4.
- Get addr 0x7FFFFFF0 and Get addr BASE+DEPTH*16 -> d_denied=1, d_corrupt=1, d_data=0; the RAM is not accessed; the arbiter proceeds normally.
- RSTn driven low during RESP beat 2 of a 4-beat Get -> next cycle d_valid=0 and a_ready=0; after release a fresh Get completes correctly.
